move_io_control_unit: RTL



---
 rtl/move_io_control_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/move_io_control_unit.sv
// rtl/move_io_control_unit.sv - hard-wired sequencer for mfhi/mflo/in/out/nop/halt
// Four-step fetch/execute cycle (T0-T2 fetch, T3 execute) driving datapath strobes.
module move_io_control_unit #(
   parameter logic [4:0] OP_MFHI = 5'b11000,
   parameter logic [4:0] OP_MFLO = 5'b11001,
   parameter logic [4:0] OP_IN   = 5'b10110,
   parameter logic [4:0] OP_OUT  = 5'b10111,
   parameter logic [4:0] OP_NOP  = 5'b11010,
   parameter logic [4:0] OP_HALT = 5'b11011
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR_Data,
   input  logic        Stop,
   output logic        PC_out,
   output logic        PC_in,
   output logic        IncPC,
   output logic        MAR_in,
   output logic        MDR_in,
   output logic        MDR_out,
   output logic        Read,
   output logic        Write,
   output logic        Z_in,
   output logic        Zlow_out,
   output logic        Zhigh_out,
   output logic        Y_in,
   output logic        IR_in,
   output logic        HI_out,
   output logic        LO_out,
   output logic        HI_in,
   output logic        LO_in,
   output logic        InPort_out,
   output logic        OutPort_in,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Run,
   output logic        Illegal
);

   typedef enum logic [2:0] {
      S_RESET = 3'd0,
      S_T0    = 3'd1,
      S_T1    = 3'd2,
      S_T2    = 3'd3,
      S_T3    = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [4:0] w_opcode;
   logic       w_unused_ir;

   assign w_opcode    = IR_Data[31:27];
   assign w_unused_ir = ^IR_Data[26:0];

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_state <= S_RESET;
      end else begin
         r_state <= w_next;
      end
   end

   // Stop is only honoured at the T3 boundary so an instruction always completes.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RESET: w_next = S_T0;
         S_T0:    w_next = S_T1;
         S_T1:    w_next = S_T2;
         S_T2:    w_next = S_T3;
         S_T3:    w_next = ((w_opcode == OP_HALT) || Stop) ? S_HALT : S_T0;
         S_HALT:  w_next = S_HALT;
         default: w_next = S_RESET;
      endcase
   end

   always_comb begin
      PC_out     = 1'b0;
      PC_in      = 1'b0;
      IncPC      = 1'b0;
      MAR_in     = 1'b0;
      MDR_in     = 1'b0;
      MDR_out    = 1'b0;
      Read       = 1'b0;
      Write      = 1'b0;
      Z_in       = 1'b0;
      Zlow_out   = 1'b0;
      Zhigh_out  = 1'b0;
      Y_in       = 1'b0;
      IR_in      = 1'b0;
      HI_out     = 1'b0;
      LO_out     = 1'b0;
      HI_in      = 1'b0;
      LO_in      = 1'b0;
      InPort_out = 1'b0;
      OutPort_in = 1'b0;
      Gra        = 1'b0;
      Grb        = 1'b0;
      Grc        = 1'b0;
      Rin        = 1'b0;
      Rout       = 1'b0;
      BAout      = 1'b0;
      Run        = 1'b0;
      Illegal    = 1'b0;
      case (r_state)
         S_T0: begin
            PC_out = 1'b1;
            MAR_in = 1'b1;
            IncPC  = 1'b1;
            Z_in   = 1'b1;
            Run    = 1'b1;
         end
         S_T1: begin
            Zlow_out = 1'b1;
            PC_in    = 1'b1;
            Read     = 1'b1;
            MDR_in   = 1'b1;
            Run      = 1'b1;
         end
         S_T2: begin
            MDR_out = 1'b1;
            IR_in   = 1'b1;
            Run     = 1'b1;
         end
         S_T3: begin
            Run = 1'b1;
            case (w_opcode)
               OP_MFHI: begin
                  Gra    = 1'b1;
                  Rin    = 1'b1;
                  HI_out = 1'b1;
               end
               OP_MFLO: begin
                  Gra    = 1'b1;
                  Rin    = 1'b1;
                  LO_out = 1'b1;
               end
               OP_IN: begin
                  Gra        = 1'b1;
                  Rin        = 1'b1;
                  InPort_out = 1'b1;
               end
               OP_OUT: begin
                  Gra        = 1'b1;
                  Rout       = 1'b1;
                  OutPort_in = 1'b1;
               end
               OP_NOP, OP_HALT: ;
               default: Illegal = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

endmodule
